data_mem_ctrl: RTL
==================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, word-address width.
REQ-002 SHALL have parameter DATA_BITS, default 8, word width.
REQ-003 SHALL have parameter NUM_CHANNELS, default 4, number of requester channels (legal 1..16).
REQ-004 SHALL have parameter LATENCY, default 2, grant-to-ready cycles (legal 1..8).
REQ-005 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port read_valid  in  NUM_CHANNELS  per-channel read request, held until acknowledged.
REQ-008 SHALL have port read_address  in  NUM_CHANNELS*ADDR_BITS  flat; channel c at bits [(c+1)*ADDR_BITS-1 : c*ADDR_BITS].
REQ-009 SHALL have port read_ready  out  NUM_CHANNELS  one-cycle read acknowledge.
REQ-010 SHALL have port read_data  out  NUM_CHANNELS*DATA_BITS  flat; valid only while read_ready[c]=1.
REQ-011 SHALL have port write_valid  in  NUM_CHANNELS  per-channel write request, held until acknowledged.
REQ-012 SHALL have port write_address  in  NUM_CHANNELS*ADDR_BITS  flat, same packing as read_address.
REQ-013 SHALL have port write_data  in  NUM_CHANNELS*DATA_BITS  flat.
REQ-014 SHALL have port write_ready  out  NUM_CHANNELS  one-cycle write acknowledge.

Function
REQ-015 SHALL hold a single-port array of 2**ADDR_BITS words; at most one access (read or write) per cycle.
REQ-016 SHALL keep a per-channel FSM: IDLE -> ISSUED on grant; ISSUED -> ACK after LATENCY-1 further cycles; ACK -> HOLD after one cycle; HOLD -> IDLE in the first cycle with read_valid[c]=0 and write_valid[c]=0.
REQ-017 SHALL consider a channel eligible only in IDLE with read_valid[c] or write_valid[c] high.
REQ-018 SHALL arbitrate eligible channels round-robin: search starts at (last granted + 1) mod NUM_CHANNELS; pointer resets to 0, so channel 0 wins the first contended cycle.
REQ-019 SHALL give a write priority over a read when both valids are high on one channel; the read is served on a later grant after HOLD->IDLE.
REQ-020 SHALL sample address/data at the grant edge; a write commits to the array on that edge; a read captures the array word at that edge (write-before-read across cycles, no same-cycle hazard).
REQ-021 SHALL assert read_ready[c] or write_ready[c] exactly LATENCY cycles after the grant edge, for exactly one cycle, with read_data[c] equal to the captured word.
REQ-022 SHALL drive read_data[c] to zero whenever read_ready[c]=0.
REQ-023 SHALL sustain one grant per cycle when requests are pending (LATENCY overlapping in-flight accesses across channels).
REQ-024 SHALL ignore address/data changes on a channel after its grant until it returns to IDLE.

Reset
REQ-025 SHALL on reset low clear all read_ready, write_ready, read_data to 0, all channel FSMs to IDLE, in-flight pipeline to empty, arbiter pointer to 0, asynchronously.
REQ-026 SHALL discard in-flight accesses at reset (no ready pulse after release); writes already committed remain; array contents are not reset.

Configuration
REQ-027 SHALL, with DATA_MEM_BACKDOOR_EN defined, add ports bd_we (in 1), bd_addr (in ADDR_BITS), bd_wdata (in DATA_BITS), bd_rdata (out DATA_BITS): bd_we writes the array on clk edge with priority over the granted write to the same address; bd_rdata is combinational array read.
REQ-028 SHALL, without DATA_MEM_BACKDOOR_EN, omit those ports with no other behavioural change.

Structure
REQ-029 SHALL place the channel FSM state enum and default parameter constants in shared package gpu_mem_pkg.
REQ-030 SHALL implement arbitration in sub-module rr_arbiter (request vector in, one-hot grant plus pointer update out).

Verification
REQ-031 Single read: mem[5]=8'h2A, ch0 read_valid addr 5 at cycle 0, LATENCY=2 -> read_ready[0]=1 with data 8'h2A at cycle 2 only.
REQ-032 Contention: all 4 channels read addresses 0..3 (values 0..3) in the same cycle -> acks in order ch0,ch1,ch2,ch3 on consecutive cycles 2..5, correct data each.
REQ-033 RAW: ch1 writes 8'h77 to addr 16, ch2 reads addr 16 one cycle later -> ch2 returns 8'h77.
REQ-034 Held valid: ch0 keeps read_valid high 3 cycles after ack -> no second ack until valid dropped one cycle then re-raised.
REQ-035 Reset mid-flight: reset low one cycle after grant -> no ready pulse ever for that request; outputs 0 during reset.
REQ-036 Matrix add: 8 reads of A and B (0..7), writes C[i]=A[i]+B[i] at 16..23 via 4 channels -> C = 0,2,4,...,14.

Source files
------------

// File: rtl/gpu_mem_pkg.sv
// gpu_mem_pkg: shared channel FSM states and default parameters for the data memory controller
package gpu_mem_pkg;
  localparam int DEF_ADDR_BITS = 8;
  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_NUM_CHANNELS = 4;
  localparam int DEF_LATENCY = 2;
  typedef enum logic [1:0] {CH_IDLE, CH_ISSUED, CH_ACK, CH_HOLD} ch_state_t;
  function automatic int ptr_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick among requesters, search starting at ptr; returns one-hot grant and the next pointer
module rr_arbiter #(
  parameter int N = 4,
  parameter int PW = 2
)(
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          any,
  output logic [PW-1:0] next_ptr
);
  logic [PW-1:0] idx;
  int best;
  int d;
  // closest requester at or after ptr (modulo N) wins
  always_comb begin
    idx = '0;
    best = N;
    d = 0;
    for (int j = 0; j < N; j++) begin
      d = (j + N - int'(ptr)) % N;
      if (req[j] && d < best) begin
        best = d;
        idx = PW'(j);
      end
    end
    any = |req;
    gnt = any ? (N'(1) << idx) : '0;
    next_ptr = PW'((int'(idx) + 1) % N);
  end
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: multi-channel single-port data memory with round-robin grants and fixed-latency acks (optional DATA_MEM_BACKDOOR_EN adds a backdoor port)
module data_mem_ctrl import gpu_mem_pkg::*; #(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int LATENCY = DEF_LATENCY
)(
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CHANNELS-1:0]           read_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] read_address,
  output logic [NUM_CHANNELS-1:0]           read_ready,
  output logic [NUM_CHANNELS*DATA_BITS-1:0] read_data,
  input  logic [NUM_CHANNELS-1:0]           write_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] write_address,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0] write_data,
  output logic [NUM_CHANNELS-1:0]           write_ready
`ifdef DATA_MEM_BACKDOOR_EN
  ,
  input  logic                              bd_we,
  input  logic [ADDR_BITS-1:0]              bd_addr,
  input  logic [DATA_BITS-1:0]              bd_wdata,
  output logic [DATA_BITS-1:0]              bd_rdata
`endif
);
  localparam int PW = ptr_bits(NUM_CHANNELS);
  localparam logic [2:0] CNT_INIT = 3'((LATENCY > 1) ? LATENCY - 2 : 0);
  ch_state_t st [NUM_CHANNELS];
  ch_state_t st_nx [NUM_CHANNELS];
  logic [2:0] cnt [NUM_CHANNELS];
  logic [2:0] cnt_nx [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] is_wr, req, gnt;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] rdata_q;
  logic [PW-1:0] ptr, ptr_nx;
  logic gnt_any, we_g;
  logic [ADDR_BITS-1:0] addr_g;
  logic [DATA_BITS-1:0] wd_g;
  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  // only idle channels with a pending request compete
  always_comb begin
    req = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) req[c] = st[c] == CH_IDLE && (read_valid[c] || write_valid[c]);
  end

  rr_arbiter #(.N(NUM_CHANNELS), .PW(PW)) u_arb (
    .req(req),
    .ptr(ptr),
    .gnt(gnt),
    .any(gnt_any),
    .next_ptr(ptr_nx)
  );

  // steer the granted channel's address/data to the array; write wins over read on one channel
  always_comb begin
    we_g = 1'b0;
    addr_g = '0;
    wd_g = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (gnt[c]) begin
        we_g = write_valid[c];
        addr_g = write_valid[c] ? write_address[c*ADDR_BITS +: ADDR_BITS] : read_address[c*ADDR_BITS +: ADDR_BITS];
        wd_g = write_data[c*DATA_BITS +: DATA_BITS];
      end
    end
  end

  // per-channel FSM next state: grant, latency countdown, one-cycle ack, hold until valids drop
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      st_nx[c] = st[c];
      cnt_nx[c] = cnt[c];
      case (st[c])
        CH_IDLE: begin
          if (gnt[c]) begin
            st_nx[c] = (LATENCY == 1) ? CH_ACK : CH_ISSUED;
            cnt_nx[c] = CNT_INIT;
          end
        end
        CH_ISSUED: begin
          if (cnt[c] == '0) st_nx[c] = CH_ACK;
          else cnt_nx[c] = cnt[c] - 3'd1;
        end
        CH_ACK: st_nx[c] = CH_HOLD;
        default: st_nx[c] = (!read_valid[c] && !write_valid[c]) ? CH_IDLE : CH_HOLD;
      endcase
    end
  end

  // channel state, captured read words and arbiter pointer; reset drops everything in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        st[c] <= CH_IDLE;
        cnt[c] <= '0;
      end
      is_wr <= '0;
      rdata_q <= '0;
      ptr <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        st[c] <= st_nx[c];
        cnt[c] <= cnt_nx[c];
        if (gnt[c]) is_wr[c] <= write_valid[c];
        if (gnt[c] && !write_valid[c]) rdata_q[c] <= mem[addr_g];
      end
      if (gnt_any) ptr <= ptr_nx;
    end
  end

  // array write on the grant edge; contents survive reset, backdoor write lands last so it wins
  always_ff @(posedge clk) begin
    if (we_g) mem[addr_g] <= wd_g;
`ifdef DATA_MEM_BACKDOOR_EN
    if (bd_we) mem[bd_addr] <= bd_wdata;
`endif
  end

`ifdef DATA_MEM_BACKDOOR_EN
  assign bd_rdata = mem[bd_addr];
`endif

  // acks come straight from the ACK state; read data is zero outside its ack cycle
  always_comb begin
    read_ready = '0;
    write_ready = '0;
    read_data = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      read_ready[c] = st[c] == CH_ACK && !is_wr[c];
      write_ready[c] = st[c] == CH_ACK && is_wr[c];
      read_data[c*DATA_BITS +: DATA_BITS] = read_ready[c] ? rdata_q[c] : '0;
    end
  end
endmodule
